// File: rtl/reg_bank_arbiter_if.sv
// Requester-side write bus for reg_bank_arbiter.
// Carries one valid/lock/address/data lane per requester and the one-hot
// ready (grant) vector returned by the arbiter.
//   req_valid  requester i has a write pending
//   req_lock   requester i wants to keep the grant after this write
//   req_addr   packed addresses, lane i at [i*ADDR_W +: ADDR_W]
//   req_data   packed write data, lane i at [i*DATA_W +: DATA_W]
//   req_ready  one-hot grant, a subset of req_valid
// Modports: master (requester logic), slave (arbiter).
interface reg_bank_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 2,
  parameter int unsigned DATA_W  = 4
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;

  modport master (
    output req_valid, req_lock, req_addr, req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_lock, req_addr, req_data,
    output req_ready
  );
endinterface

// File: rtl/reg_bank_arbiter.sv
// Shared register bank with a round-robin write arbiter and bounded locking.
// One write per cycle is granted; a locked owner keeps the grant for at most
// LOCK_MAX consecutive writes. A separate registered read port returns the
// bank contents with one cycle of latency (old value on a same-cycle write).
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        requester write bus (slave modport of reg_bank_arbiter_if)
//   rd_addr    read address
//   rd_data    registered read data, 0 for out-of-range addresses
//   busy       high while a requester holds the lock
// Optional: define REG_ARB_STATS_EN to add stats_clr (synchronous clear) and
//   grant_cnt (per-requester saturating 8-bit count of accepted writes).
module reg_bank_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DATA_W   = 4,
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned ADDR_W   = 2,
  parameter int unsigned LOCK_MAX = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  reg_bank_arbiter_if.slave         bus,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      busy
`ifdef REG_ARB_STATS_EN
  ,
  input  logic                      stats_clr,
  output logic [NUM_REQ*8-1:0]      grant_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e             state_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   owner_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  bank_q [NUM_REGS];

  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   ptr_next;
  logic               fire;
  logic               found;
  int unsigned        idx;
  logic [ADDR_W-1:0]  wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic               wr_in_range;
  logic               rd_in_range;

  // Grant selection: rotating priority from ptr_q when idle, owner only when locked.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    if (state_q == StIdle) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = 32'(ptr_q) + 32'(k);
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!found && bus.req_valid[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          gnt_idx    = PTR_W'(idx);
        end
      end
    end else if (bus.req_valid[owner_q]) begin
      grant[owner_q] = 1'b1;
      gnt_idx        = owner_q;
    end
    // Reset is asynchronous, so the combinational grant must drop with it.
    if (!rst_n) grant = '0;
  end

  assign bus.req_ready = grant;
  assign fire          = |grant;
  assign ptr_next      = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + PTR_W'(1);

  assign wr_addr     = bus.req_addr[32'(gnt_idx)*ADDR_W +: ADDR_W];
  assign wr_data     = bus.req_data[32'(gnt_idx)*DATA_W +: DATA_W];
  assign wr_in_range = 32'(wr_addr) < NUM_REGS;
  assign rd_in_range = 32'(rd_addr) < NUM_REGS;

  // Arbiter FSM. cnt_q counts grants already taken in the current lock, so
  // the owner leaves once the grant just accepted makes LOCK_MAX in total.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
    end else begin
      if (fire) ptr_q <= ptr_next;
      unique case (state_q)
        StIdle: begin
          if (fire && bus.req_lock[gnt_idx] && (LOCK_MAX > 1)) begin
            state_q <= StLocked;
            owner_q <= gnt_idx;
            cnt_q   <= CNT_W'(1);
            busy    <= 1'b1;
          end
        end
        StLocked: begin
          if (fire && bus.req_lock[owner_q] && (32'(cnt_q) + 1 < LOCK_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            // Bound reached, lock released, or owner went idle.
            state_q <= StIdle;
            cnt_q   <= '0;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Storage and read port; the read samples bank_q before this edge's write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) bank_q[i] <= '0;
      rd_data <= '0;
    end else begin
      if (fire && wr_in_range) bank_q[wr_addr] <= wr_data;
      rd_data <= rd_in_range ? bank_q[rd_addr] : '0;
    end
  end

`ifdef REG_ARB_STATS_EN
  logic [7:0] stat_q [NUM_REQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (stats_clr) begin
          stat_q[i] <= '0;
        end else if (grant[i] && (stat_q[i] != 8'hFF)) begin
          stat_q[i] <= stat_q[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) grant_cnt[i*8 +: 8] = stat_q[i];
  end
`endif

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed self-checking bench for reg_bank_arbiter (default parameters).
// Inputs change 1 time unit after the rising edge; outputs are checked a
// further unit later, away from the active edge.
module tb_reg_bank_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 4;
  localparam int unsigned ADDR_W  = 2;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
`ifdef REG_ARB_STATS_EN
  logic              stats_clr;
  logic [NUM_REQ*8-1:0] grant_cnt;
`endif

  int unsigned n_checks;
  int unsigned n_errors;

  reg_bank_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  reg_bank_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy)
`ifdef REG_ARB_STATS_EN
    ,
    .stats_clr (stats_clr),
    .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic l,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.req_valid[i]                   = v;
    bus.req_lock[i]                    = l;
    bus.req_addr[i*ADDR_W +: ADDR_W]   = a;
    bus.req_data[i*DATA_W +: DATA_W]   = d;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_lock  = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < 4; a++) begin
      rd_addr = ADDR_W'(a);
      tick();
      check({tag, "_rd"}, 32'(rd_data), 32'h0);
      check({tag, "_ready"}, 32'(bus.req_ready), 32'h0);
      check({tag, "_busy"}, 32'(busy), 32'h0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    rd_addr  = '0;
`ifdef REG_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    clear_reqs();

    // Reset held for two edges, then read the whole bank.
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.req_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rd", 32'(rd_data), 32'h0);
    rst_n = 1'b1;
    read_all_zero("post_rst");

    // Round robin from pointer 0: requester i writes i+1 to address i.
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, ADDR_W'(i), DATA_W'(i + 1));
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rr_grant", 32'(bus.req_ready), 32'(1) << (k % 4));
      check("rr_busy", 32'(busy), 32'h0);
      tick();
    end
    clear_reqs();
`ifdef REG_ARB_STATS_EN
    check("rr_stats", 32'(grant_cnt), 32'h02020202);
`endif

    // Single write from requester 0 (pointer back at 0), read back next cycle.
    set_req(0, 1'b1, 1'b0, 2'd2, 4'hA);
    #1;
    check("single_ready", 32'(bus.req_ready), 32'h1);
    tick();
    clear_reqs();
    rd_addr = 2'd2;
    #1;
    check("single_idle_ready", 32'(bus.req_ready), 32'h0);
    tick();
    check("single_rd", 32'(rd_data), 32'hA);

    // Lock bound: pointer is 1; requester 1 locks with everyone valid.
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, (i == 1), ADDR_W'(i), 4'hC);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("lock_grant", 32'(bus.req_ready), 32'h2);
      check("lock_busy", 32'(busy), (k > 0) ? 32'h1 : 32'h0);
      tick();
    end
    #1;
    check("lock_after_grant", 32'(bus.req_ready), 32'h4);
    check("lock_after_busy", 32'(busy), 32'h0);
    clear_reqs();
    tick();

    // Owner drop: pointer 2; requester 2 locks, then goes idle while others wait.
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, (i == 2), (i == 2) ? 2'd0 : ADDR_W'(i),
                                        (i == 2) ? 4'h7 : 4'h0);
    #1;
    check("drop_first", 32'(bus.req_ready), 32'h4);
    tick();
    set_req(2, 1'b0, 1'b0, 2'd0, 4'h0);
    #1;
    check("drop_others_blocked", 32'(bus.req_ready), 32'h0);
    check("drop_busy", 32'(busy), 32'h1);
    tick();
    #1;
    check("drop_idle_grant", 32'(bus.req_ready), 32'h8);
    check("drop_idle_busy", 32'(busy), 32'h0);
    clear_reqs();
    tick();

    // Same-cycle write/read hazard on address 3 (pointer 3, only req0 valid).
    set_req(0, 1'b1, 1'b0, 2'd3, 4'h5);
    rd_addr = 2'd0;
    #1;
    check("haz_ready", 32'(bus.req_ready), 32'h1);
    tick();
    check("haz_rd_bank0", 32'(rd_data), 32'h7);
    set_req(0, 1'b1, 1'b0, 2'd3, 4'h9);
    rd_addr = 2'd3;
    tick();
    check("haz_old", 32'(rd_data), 32'h5);
    clear_reqs();
    tick();
    check("haz_new", 32'(rd_data), 32'h9);
    rd_addr = 2'd1;
    tick();
    check("lock_wrote_bank1", 32'(rd_data), 32'hC);

    // Asynchronous reset while locked (pointer 1, requester 1 locks).
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, (i == 1), ADDR_W'(i), 4'h3);
    #1;
    check("arst_grant", 32'(bus.req_ready), 32'h2);
    tick();
    #1;
    check("arst_locked_busy", 32'(busy), 32'h1);
    check("arst_locked_ready", 32'(bus.req_ready), 32'h2);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_busy_drop", 32'(busy), 32'h0);
    check("arst_ready_drop", 32'(bus.req_ready), 32'h0);
    clear_reqs();
    tick();
    tick();
    rst_n = 1'b1;
    read_all_zero("arst_bank");
`ifdef REG_ARB_STATS_EN
    check("arst_stats", 32'(grant_cnt), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
